// File: rtl/axis_cntr_pkg.sv
// Shared encodings and tdata bit positions for the AXIS timestamp source.
package axis_cntr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_BURST = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic MODE_CONT  = 1'b0;
  localparam logic MODE_BURST = 1'b1;

  function automatic int drop_bit(input int w);
    return w - 1;
  endfunction

  function automatic int trg_bit(input int w);
    return w - 2;
  endfunction

endpackage

// File: rtl/axis_stamp_oreg.sv
// One-deep AXIS output register: load/drop decision, pending flags,
// saturating drop counter.
module axis_stamp_oreg
  import axis_cntr_pkg::*;
#(
  parameter int W  = 64,
  parameter int CW = 48,
  parameter int DW = 32
) (
  input  logic          aclk,
  input  logic          aresetn,
  input  logic          smp_vld_i,
  input  logic          smp_trg_i,
  input  logic          smp_last_i,
  input  logic [CW-1:0] smp_cntr_i,
  input  logic          tready_i,
  output logic [W-1:0]  tdata_o,
  output logic          tvalid_o,
  output logic          tlast_o,
  output logic [DW-1:0] drop_cntr_o
);

  localparam int DB = drop_bit(W);
  localparam int TB = trg_bit(W);

  logic [W-1:0]  tdata_q;
  logic          tvalid_q;
  logic          tlast_q;
  logic          drop_pend_q;
  logic          trg_pend_q;
  logic [DW-1:0] drop_cntr_q;

  logic          load;
  logic          drop;
  logic [W-1:0]  word_d;

  assign load = smp_vld_i & (~tvalid_q | tready_i);
  assign drop = smp_vld_i & tvalid_q & ~tready_i;

  // A dropped sample's trigger mark survives in trg_pend_q.
  always_comb begin
    word_d           = '0;
    word_d[CW-1:0]   = smp_cntr_i;
    word_d[DB]       = drop_pend_q;
    word_d[TB]       = trg_pend_q | smp_trg_i;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      drop_pend_q <= 1'b0;
      trg_pend_q  <= 1'b0;
      drop_cntr_q <= '0;
    end else begin
      if (load) begin
        tdata_q  <= word_d;
        tlast_q  <= smp_last_i;
        tvalid_q <= 1'b1;
      end else if (tready_i) begin
        tvalid_q <= 1'b0;
      end
      drop_pend_q <= load ? 1'b0 : (drop_pend_q | drop);
      trg_pend_q  <= load ? 1'b0 : (trg_pend_q | smp_trg_i);
      if (drop && (drop_cntr_q != '1))
        drop_cntr_q <= drop_cntr_q + 1'b1;
    end
  end

  assign tdata_o     = tdata_q;
  assign tvalid_o    = tvalid_q;
  assign tlast_o     = tlast_q;
  assign drop_cntr_o = drop_cntr_q;

endmodule

// File: rtl/axis_stamp_counter.sv
// Free-running timestamp counter streamed over AXIS, continuous or
// triggered-burst.
module axis_stamp_counter
  import axis_cntr_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = 64,
  parameter int CNTR_WIDTH       = 48,
  parameter int PKT_LEN_WIDTH    = 16,
  parameter int DROP_CNTR_WIDTH  = 32
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        cfg_mode,
  input  logic [PKT_LEN_WIDTH-1:0]    cfg_pkt_len,
  input  logic                        run_flag,
  input  logic                        trg_flag,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  output logic                        m_axis_tlast,
  input  logic                        m_axis_tready,
  output logic [DROP_CNTR_WIDTH-1:0]  sts_drop_cntr,
  output logic [1:0]                  sts_state
);

  localparam int PW = PKT_LEN_WIDTH;
  localparam logic [PW-1:0] ONE = PW'(1);

  state_t          state_q;
  logic [CNTR_WIDTH-1:0] cntr_q;
  logic            mode_q;
  logic [PW-1:0]   len_q;
  logic [PW-1:0]   bcnt_q;

  logic [PW-1:0]   len_eff;
  logic            in_run;
  logic            in_burst;
  logic            cnt_en;
  logic            smp_vld;
  logic            smp_trg;
  logic            smp_last;

  assign len_eff  = (len_q == '0) ? ONE : len_q;
  assign in_run   = (state_q == ST_RUN) & run_flag;
  assign in_burst = (state_q == ST_BURST) & run_flag;
  assign cnt_en   = (state_q != ST_IDLE) & run_flag;

  assign smp_vld  = (in_run & (mode_q == MODE_CONT)) | in_burst;
  assign smp_trg  = (in_run & (mode_q == MODE_CONT) & trg_flag)
                  | (in_burst & (bcnt_q == ONE));
  assign smp_last = in_burst & (bcnt_q == len_eff);

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;
      cntr_q  <= '0;
      mode_q  <= MODE_CONT;
      len_q   <= '0;
      bcnt_q  <= '0;
    end else begin
      if (cnt_en)
        cntr_q <= cntr_q + 1'b1;
      unique case (state_q)
        ST_IDLE: begin
          if (run_flag) begin
            state_q <= ST_RUN;
            mode_q  <= cfg_mode;
            len_q   <= cfg_pkt_len;
          end
        end
        ST_RUN: begin
          if (!run_flag) begin
            state_q <= ST_IDLE;
          end else if ((mode_q == MODE_BURST) && trg_flag) begin
            state_q <= ST_BURST;
            bcnt_q  <= ONE;
          end
        end
        ST_BURST: begin
          if (!run_flag)
            state_q <= ST_IDLE;
          else if (smp_last)
            state_q <= ST_DONE;
          else
            bcnt_q <= bcnt_q + 1'b1;
        end
        ST_DONE: begin
          if (!run_flag)
            state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  axis_stamp_oreg #(
    .W  (AXIS_TDATA_WIDTH),
    .CW (CNTR_WIDTH),
    .DW (DROP_CNTR_WIDTH)
  ) u_oreg (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .smp_vld_i   (smp_vld),
    .smp_trg_i   (smp_trg),
    .smp_last_i  (smp_last),
    .smp_cntr_i  (cntr_q),
    .tready_i    (m_axis_tready),
    .tdata_o     (m_axis_tdata),
    .tvalid_o    (m_axis_tvalid),
    .tlast_o     (m_axis_tlast),
    .drop_cntr_o (sts_drop_cntr)
  );

  assign sts_state = state_q;

endmodule

// File: tb/tb_axis_stamp_counter.sv
// Directed bench: per-cycle vector table plus burst, wrap and reset
// sequences.
module tb_axis_stamp_counter;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        cfg_mode = 1'b0;
  logic [15:0] cfg_pkt_len = '0;
  logic        run_flag = 1'b0;
  logic        trg_flag = 1'b0;
  logic        tready = 1'b1;

  logic [63:0] td0;
  logic        tv0, tl0;
  logic [31:0] dc0;
  logic [1:0]  st0;
  logic [7:0]  td1;
  logic        tv1, tl1;
  logic [31:0] dc1;
  logic [1:0]  st1;

  int nvec = 0;
  int nerr = 0;

  always #5 aclk = ~aclk;

  axis_stamp_counter u0 (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .cfg_mode      (cfg_mode),
    .cfg_pkt_len   (cfg_pkt_len),
    .run_flag      (run_flag),
    .trg_flag      (trg_flag),
    .m_axis_tdata  (td0),
    .m_axis_tvalid (tv0),
    .m_axis_tlast  (tl0),
    .m_axis_tready (tready),
    .sts_drop_cntr (dc0),
    .sts_state     (st0)
  );

  axis_stamp_counter #(
    .AXIS_TDATA_WIDTH (8),
    .CNTR_WIDTH       (4)
  ) u1 (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .cfg_mode      (cfg_mode),
    .cfg_pkt_len   (cfg_pkt_len),
    .run_flag      (run_flag),
    .trg_flag      (trg_flag),
    .m_axis_tdata  (td1),
    .m_axis_tvalid (tv1),
    .m_axis_tlast  (tl1),
    .m_axis_tready (tready),
    .sts_drop_cntr (dc1),
    .sts_state     (st1)
  );

  typedef struct {
    logic        rstn, run, trg, rdy;
    logic        ev;
    logic [63:0] ed;
    logic        el;
    logic [1:0]  es;
    logic [31:0] edc;
  } vec_t;

  vec_t tab[$];

  function automatic logic [63:0] mk(input logic d, input logic t,
                                     input logic [47:0] c);
    return {d, t, 14'b0, c};
  endfunction

  function automatic vec_t v(input logic rs, input logic r,
                             input logic t, input logic rd,
                             input logic ev, input logic [63:0] ed,
                             input logic el, input logic [1:0] es,
                             input logic [31:0] edc);
    vec_t x;
    x.rstn = rs; x.run = r; x.trg = t; x.rdy = rd;
    x.ev = ev; x.ed = ed; x.el = el; x.es = es; x.edc = edc;
    return x;
  endfunction

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string n, input logic [72:0] a,
                     input logic [72:0] e);
    nvec++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask

  task automatic do_reset();
    aresetn = 1'b0; run_flag = 1'b0; trg_flag = 1'b0;
    tick();
    aresetn = 1'b1;
  endtask

  initial begin
    // Mode 0: start, backpressure drops, trigger marks, stop/restart.
    tab.push_back(v(0,0,0,1, 0,'0,0,0,0));
    tab.push_back(v(1,1,0,1, 0,'0,0,1,0));
    tab.push_back(v(1,1,0,1, 1,mk(0,0,0),0,1,0));
    tab.push_back(v(1,1,0,1, 1,mk(0,0,1),0,1,0));
    tab.push_back(v(1,1,0,1, 1,mk(0,0,2),0,1,0));
    tab.push_back(v(1,1,0,0, 1,mk(0,0,2),0,1,1));
    tab.push_back(v(1,1,0,0, 1,mk(0,0,2),0,1,2));
    tab.push_back(v(1,1,0,0, 1,mk(0,0,2),0,1,3));
    tab.push_back(v(1,1,0,0, 1,mk(0,0,2),0,1,4));
    tab.push_back(v(1,1,0,0, 1,mk(0,0,2),0,1,5));
    tab.push_back(v(1,1,0,1, 1,mk(1,0,8),0,1,5));
    tab.push_back(v(1,1,0,1, 1,mk(0,0,9),0,1,5));
    tab.push_back(v(1,1,1,1, 1,mk(0,1,10),0,1,5));
    tab.push_back(v(1,1,0,1, 1,mk(0,0,11),0,1,5));
    tab.push_back(v(1,1,1,0, 1,mk(0,0,11),0,1,6));
    tab.push_back(v(1,1,0,1, 1,mk(1,1,13),0,1,6));
    tab.push_back(v(1,0,0,0, 1,mk(1,1,13),0,0,6));
    tab.push_back(v(1,0,1,1, 0,'0,0,0,6));
    tab.push_back(v(1,1,1,1, 0,'0,0,1,6));
    tab.push_back(v(1,1,0,1, 1,mk(0,0,14),0,1,6));
    tab.push_back(v(1,0,0,1, 0,'0,0,0,6));

    cfg_mode = 1'b0;
    foreach (tab[i]) begin
      aresetn  = tab[i].rstn;
      run_flag = tab[i].run;
      trg_flag = tab[i].trg;
      tready   = tab[i].rdy;
      tick();
      chk($sformatf("vec%0d_ctl", i), {tv0, st0, dc0},
          {tab[i].ev, tab[i].es, tab[i].edc});
      if (tab[i].ev)
        chk($sformatf("vec%0d_data", i), {tl0, td0},
            {tab[i].el, tab[i].ed});
    end

    // Triggered burst of 4 words, second trigger ignored in DONE.
    do_reset();
    cfg_mode = 1'b1; cfg_pkt_len = 16'd4; tready = 1'b1;
    run_flag = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("burst_wait", {tv0, st0}, {1'b1 ^ 1'b1, 2'd1});
    end
    trg_flag = 1'b1;
    tick();
    trg_flag = 1'b0;
    chk("burst_enter", {tv0, st0}, {1'b0, 2'd2});
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("burst_w%0d", i), {tv0, tl0, td0},
          {1'b1, (i == 3), mk(0, (i == 0), 48'(6 + i))});
    end
    chk("burst_done", {7'd0, st0}, {7'd0, 2'd3});
    trg_flag = 1'b1;
    tick();
    trg_flag = 1'b0;
    chk("burst_retrg", {tv0, st0}, {1'b0, 2'd3});
    tick();
    chk("burst_hold", {tv0, st0}, {1'b0, 2'd3});
    run_flag = 1'b0;
    tick();
    chk("burst_idle", {7'd0, st0}, {7'd0, 2'd0});

    // 4-bit counter wrap on the narrow instance.
    do_reset();
    cfg_mode = 1'b0; tready = 1'b1;
    run_flag = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) begin
      tick();
      chk($sformatf("wrap%0d", i), {tv1, tl1, td1},
          {1'b1, 1'b0, 8'(i % 16)});
    end

    // Zero packet length yields a single tlast word.
    do_reset();
    cfg_mode = 1'b1; cfg_pkt_len = 16'd0;
    run_flag = 1'b1;
    tick();
    trg_flag = 1'b1;
    tick();
    trg_flag = 1'b0;
    tick();
    chk("len0_word", {tv0, tl0, td0}, {1'b1, 1'b1, mk(0,1,1)});
    chk("len0_state", {7'd0, st0}, {7'd0, 2'd3});
    tick();
    chk("len0_empty", {tv0, st0}, {1'b0, 2'd3});

    // Reset during a stalled burst.
    do_reset();
    cfg_mode = 1'b1; cfg_pkt_len = 16'd4; tready = 1'b0;
    run_flag = 1'b1;
    tick();
    trg_flag = 1'b1;
    tick();
    trg_flag = 1'b0;
    tick();
    tick();
    chk("stall_pre", {tv0, st0, dc0}, {1'b1, 2'd2, 32'd1});
    aresetn = 1'b0;
    tick();
    chk("rst_ctl", {tv0, st0, dc0}, {1'b0, 2'd0, 32'd0});
    chk("rst_data", {tl0, td0}, {1'b0, 64'd0});
    aresetn = 1'b1; cfg_mode = 1'b0; tready = 1'b1;
    tick();
    tick();
    chk("rst_cntr", {tv0, tl0, td0}, {1'b1, 1'b0, mk(0,0,0)});

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
